// File: rtl/inst_fetcher.sv
// Instruction fetcher: one outstanding memory request at a time, static JAL
// prediction, and a small instruction queue feeding the decoder.
module inst_fetcher #(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_inst,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        flush_in,
    input  logic [31:0] flush_pc_in,
    // Fetch state for debug: 0 = IDLE, 1 = WAIT_MEM, 2 = DISCARD.
    output logic [1:0]  dbg_state
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(QUEUE_DEPTH);
    localparam logic [6:0] OPC_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        DISCARD  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [31:0]      pc, pc_nxt, req_addr;
    logic [31:0]      q_inst [QUEUE_DEPTH];
    logic [31:0]      q_pc   [QUEUE_DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [PTR_W:0]   count;
    logic             push, pop, issue;
    logic [31:0]      jal_imm;

    // Handshakes: the request is held until the single-cycle mem_resp_valid
    // pulse completes it; the queue head transfers when inst_valid && inst_ready.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        push      = 1'b0;
        pop       = 1'b0;
        issue     = 1'b0;
        jal_imm   = {{11{mem_resp_inst[31]}}, mem_resp_inst[31], mem_resp_inst[19:12],
                     mem_resp_inst[20], mem_resp_inst[30:21], 1'b0};
        if (flush_in) begin
            pc_nxt = flush_pc_in;
            case (state)
                // An in-flight request must still be drained before reissuing.
                WAIT_MEM: state_nxt = mem_resp_valid ? IDLE : DISCARD;
                DISCARD:  if (mem_resp_valid) state_nxt = IDLE;
                default:  state_nxt = IDLE;
            endcase
        end else begin
            pop = (count != '0) && inst_ready;
            case (state)
                IDLE: begin
                    if (count < DEPTH_C) begin
                        state_nxt = WAIT_MEM;
                        issue     = 1'b1;
                    end
                end
                WAIT_MEM: begin
                    if (mem_resp_valid) begin
                        push      = 1'b1;
                        state_nxt = IDLE;
                        pc_nxt    = (mem_resp_inst[6:0] == OPC_JAL) ? pc + jal_imm : pc + 32'd4;
                    end
                end
                DISCARD: if (mem_resp_valid) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_inst[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (issue) req_addr <= pc;
            if (flush_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    q_inst[tail] <= mem_resp_inst;
                    q_pc[tail]   <= pc;
                    tail         <= tail + 1'b1;
                end
                if (pop) head <= head + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (!push && pop) count <= count - 1'b1;
            end
        end
    end

    // The issued address stays on the bus even if a flush retargets pc mid-request.
    assign mem_req_valid = (state != IDLE);
    assign mem_req_addr  = (state == IDLE) ? pc : req_addr;
    assign inst_valid    = (count != '0);
    assign inst_out      = q_inst[head];
    assign inst_pc       = q_pc[head];
    assign dbg_state     = state;

endmodule
